shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
- Multi-cycle sequencer that performs a variable 64-bit shift by reusing a fixed shift-by-2 / shift-by-1 stage over several cycles.
- Sits beside the execute stage and serves LSL/LSR/ASR requests with a shift amount of 0..63.
- Replaces a full barrel shifter with an iterative datapath, using a start/busy/done handshake.

Parameters:
- WIDTH, 64, data width in bits.
- SHAMT_W, 6, shift-amount width; must satisfy 2**SHAMT_W == WIDTH.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request strobe; sampled only in IDLE.
- op  input  2  shift type: 00 LSL, 01 LSR, 10 ASR, 11 reserved (treated as LSL).
- shamt  input  SHAMT_W  shift amount, unsigned.
- data_in  input  WIDTH  operand.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse; result valid.
- result  output  WIDTH  shifted value; held until the next accepted start.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, busy=0, done=0, result=0, rem=0, op_q=00. Reset asserted mid-operation aborts the shift; no done pulse is produced.
- Internal registers:
  - acc[WIDTH-1:0] drives result directly.
  - rem[SHAMT_W-1:0] holds the remaining shift count.
  - op_q holds the latched operation.
- IDLE:
  - start=1 at an edge: acc<=data_in, rem<=shamt, op_q<=op.
  - Next state is SHIFT if shamt!=0, else DONE.
  - start=0: stay in IDLE, acc unchanged.
- SHIFT, per edge:
  - Step size k=2 if rem>=2, else k=1.
  - LSL: acc<={acc[WIDTH-1-k:0], k zeros}.
  - LSR: zero-fill from the MSB side.
  - ASR: fill with the acc[WIDTH-1] value at the time of the step.
  - rem<=rem-k.
  - When rem-k==0, next state is DONE; otherwise stay in SHIFT.
- DONE: done=1 for exactly one cycle; next edge goes to IDLE unconditionally.
- Latency:
  - The shift occupies ceil(shamt/2) SHIFT cycles.
  - done is high in the cycle that begins ceil(shamt/2)+1 edges after the start-sampling edge (shamt=0 gives 1, shamt=63 gives 33).
  - Back-to-back throughput: a new start is accepted on the edge after DONE at the earliest.
- start while busy (SHIFT or DONE) is ignored. Operand inputs are not required to stay stable after the accepting edge.
- result is stable, and equals the final acc, from DONE until the next accepted start edge.
- Outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- Arithmetic: rem never underflows because k<=rem is guaranteed. Shift by WIDTH is unrepresentable.

Test Plan:
- Basic LSL: reset low for 2 cycles, then high. start, op=00, shamt=5, data_in=0x1 → busy for 4 cycles; done pulses once, 4 cycles after the accepting edge; result=0x20. busy=0 the cycle after done.
- LSR max: op=01, shamt=63, data_in=0x8000_0000_0000_0000 → done 33 cycles after start; result=0x1.
- ASR sign fill: op=10, shamt=4, data_in=0x8000_0000_0000_00F0 → done after 3 cycles; result=0xF800_0000_0000_000F. Repeat with data_in=0x7000_0000_0000_0000 → result=0x0700_0000_0000_0000.
- Zero shift plus ignored start: shamt=0, data_in=0xDEAD_BEEF → done the next cycle; result=0xDEAD_BEEF. Then start shamt=6 LSL 0x3; while busy, pulse start with shamt=1 data_in=0xFF → ignored; result=0xC0 after 4 cycles.
- Reset mid-op: start LSL shamt=40 data 0x1; assert reset after 5 cycles, asynchronously and between edges → busy, done and result go to 0 immediately; no done pulse. After release, a new request (LSL 2 of 0x1) completes normally with result=0x4.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - iterative LSL/LSR/ASR sequencer reusing a shift-by-2/shift-by-1 stage
module shift_seq_ctrl #(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data_in,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   acc;
  logic [SHAMT_W-1:0] rem;
  logic [1:0]         op_q;

  logic               step_two;
  logic               fill;
  logic [WIDTH-1:0]   shifted;
  logic [SHAMT_W-1:0] rem_next;

  // Outputs come from registers only: busy/done decode the state, result is acc.
  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_DONE);
  assign result = acc;

  // One shift step: move by 2 while at least 2 remain, else by 1; reserved op falls to LSL.
  always_comb begin
    step_two = (rem >= SHAMT_W'(2));
    fill     = (op_q == OP_ASR) & acc[WIDTH-1];
    shifted  = acc;
    if (op_q == OP_LSR || op_q == OP_ASR) begin
      if (step_two) shifted = {fill, fill, acc[WIDTH-1:2]};
      else          shifted = {fill, acc[WIDTH-1:1]};
    end else begin
      if (step_two) shifted = {acc[WIDTH-3:0], 2'b00};
      else          shifted = {acc[WIDTH-2:0], 1'b0};
    end
    rem_next = rem - (step_two ? SHAMT_W'(2) : SHAMT_W'(1));
  end

  // Next-state decode; a zero shift amount goes straight to DONE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = (shamt != '0) ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (rem_next == '0) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register; reset aborts any shift in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Datapath: capture operands on an accepted start, then step acc/rem each SHIFT cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc  <= '0;
      rem  <= '0;
      op_q <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc  <= data_in;
            rem  <= shamt;
            op_q <= op;
          end
        end
        ST_SHIFT: begin
          acc <= shifted;
          rem <= rem_next;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - directed table-driven bench for shift_seq_ctrl
module tb_shift_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [5:0]  shamt;
  logic [63:0] data_in;
  logic        busy;
  logic        done;
  logic [63:0] result;

  int applied;
  int miscompares;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  shamt;
    logic [63:0] data;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  shift_seq_ctrl #(.WIDTH(64), .SHAMT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .shamt(shamt),
    .data_in(data_in), .busy(busy), .done(done), .result(result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
    end
  endtask

  // Issue one request, then watch done latency, busy shape, single pulse and held result.
  // poke > 0 raises start (with junk operands) for one cycle at that observation point.
  task automatic run(input string name, input logic [1:0] o, input logic [5:0] s,
                     input logic [63:0] d, input logic [63:0] exp, input int lat, input int poke);
    int seen;
    int ndone;
    logic busy_ok;
    @(negedge clk);
    start = 1'b1; op = o; shamt = s; data_in = d;
    @(negedge clk);
    start   = 1'b0;
    data_in = {$urandom, $urandom};
    shamt   = 6'($urandom);
    op      = 2'($urandom);
    seen = 0; ndone = 0; busy_ok = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) @(negedge clk);
      start = 1'b0;
      if (done) begin
        ndone++;
        if (seen == 0) seen = n;
      end
      if (seen == 0 && !busy) busy_ok = 1'b0;
      if (n == poke) begin
        start = 1'b1; op = 2'b00; shamt = 6'd1; data_in = 64'hFF;
      end
      if (seen != 0 && n > seen) break;
    end
    chk({name, " latency"}, 64'(seen), 64'(lat));
    chk({name, " busy_before_done"}, {63'd0, busy_ok}, 64'd1);
    chk({name, " done_pulses"}, 64'(ndone), 64'd1);
    chk({name, " busy_after_done"}, {63'd0, busy}, 64'd0);
    chk({name, " result"}, result, exp);
    @(negedge clk);
    chk({name, " result_held"}, result, exp);
  endtask

  initial begin
    logic no_done;
    applied = 0;
    miscompares = 0;

    vecs[0]  = '{2'b00, 6'd5,  64'h1,                   64'h20,                  4};
    vecs[1]  = '{2'b01, 6'd63, 64'h8000_0000_0000_0000, 64'h1,                   33};
    vecs[2]  = '{2'b10, 6'd4,  64'h8000_0000_0000_00F0, 64'hF800_0000_0000_000F, 3};
    vecs[3]  = '{2'b10, 6'd4,  64'h7000_0000_0000_0000, 64'h0700_0000_0000_0000, 3};
    vecs[4]  = '{2'b00, 6'd0,  64'hDEAD_BEEF,           64'hDEAD_BEEF,           1};
    vecs[5]  = '{2'b11, 6'd1,  64'h1,                   64'h2,                   2};
    vecs[6]  = '{2'b01, 6'd1,  64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 2};
    vecs[7]  = '{2'b10, 6'd63, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    vecs[8]  = '{2'b10, 6'd2,  64'h8000_0000_0000_0000, 64'hE000_0000_0000_0000, 2};
    vecs[9]  = '{2'b00, 6'd63, 64'h1,                   64'h8000_0000_0000_0000, 33};
    vecs[10] = '{2'b00, 6'd3,  64'hF,                   64'h78,                  3};
    vecs[11] = '{2'b10, 6'd3,  64'h8000_0000_0000_0000, 64'hF000_0000_0000_0000, 3};
    vecs[12] = '{2'b01, 6'd0,  64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1};

    reset = 1'b0; start = 1'b0; op = 2'b00; shamt = 6'd0; data_in = 64'd0;
    repeat (2) @(negedge clk);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset result", result, 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 13; i++)
      run($sformatf("vec%0d", i), vecs[i].op, vecs[i].shamt, vecs[i].data, vecs[i].exp,
          vecs[i].lat, 0);

    // Start pulsed during SHIFT and during DONE must both be ignored.
    run("ignored_start_shift", 2'b00, 6'd6, 64'h3, 64'hC0, 4, 2);
    run("ignored_start_done", 2'b00, 6'd6, 64'h3, 64'hC0, 4, 4);

    // Asynchronous reset between edges aborts a long shift.
    @(negedge clk);
    start = 1'b1; op = 2'b00; shamt = 6'd40; data_in = 64'h1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midop busy_before_reset", {63'd0, busy}, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("midop reset busy", {63'd0, busy}, 64'd0);
    chk("midop reset done", {63'd0, done}, 64'd0);
    chk("midop reset result", result, 64'd0);
    no_done = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (done) no_done = 1'b0;
    end
    reset = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (done || busy) no_done = 1'b0;
    end
    chk("midop no_done_after_abort", {63'd0, no_done}, 64'd1);
    run("after_reset", 2'b00, 6'd2, 64'h1, 64'h4, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
